// File: rtl/bp_piton_fill_assembler.sv
// Collects a header flit plus up to N payload flits into one cache fill line.
// Payload beyond the line width is drained and flagged as a sticky overflow.
module bp_piton_fill_assembler #(
  parameter int flit_width_p = 64,
  parameter int fill_width_p = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [flit_width_p-1:0] flit_i,
  input  logic                    flit_v_i,
  output logic                    flit_ready_o,
  output logic [fill_width_p-1:0] fill_data_o,
  output logic [7:0]              fill_type_o,
  output logic [7:0]              fill_mshr_o,
  output logic [7:0]              fill_len_o,
  output logic                    fill_v_o,
  input  logic                    fill_yumi_i,
  output logic                    overflow_o
);

  localparam int N = fill_width_p / flit_width_p;
  localparam logic [7:0] N8 = 8'(N);

  typedef enum logic [1:0] {
    e_hdr,
    e_data,
    e_drop,
    e_out
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [fill_width_p-1:0] r_data;
  logic [7:0] r_type;
  logic [7:0] r_mshr;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic       r_ovf;

  logic       w_xfer;
  logic [7:0] w_cnt_inc;
  logic [7:0] w_fill_cnt;
  logic       w_data_last;
  logic       w_drop_last;

  assign w_xfer      = flit_v_i & flit_ready_o;
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_fill_cnt  = (r_len <= N8) ? r_len : N8;
  assign w_data_last = (w_cnt_inc == w_fill_cnt);
  assign w_drop_last = (w_cnt_inc == r_len);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= e_hdr;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    flit_ready_o = 1'b0;
    unique case (r_state)
      e_hdr: begin
        flit_ready_o = 1'b1;
        if (w_xfer) begin
          w_state_nxt = (flit_i[7:0] == 8'd0) ? e_out : e_data;
        end
      end
      e_data: begin
        flit_ready_o = 1'b1;
        if (w_xfer && w_data_last) begin
          w_state_nxt = (r_len > N8) ? e_drop : e_out;
        end
      end
      e_drop: begin
        flit_ready_o = 1'b1;
        if (w_xfer && w_drop_last) begin
          w_state_nxt = e_out;
        end
      end
      e_out: begin
        if (fill_yumi_i) begin
          w_state_nxt = e_hdr;
        end
      end
      default: w_state_nxt = e_hdr;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data <= '0;
      r_type <= 8'd0;
      r_mshr <= 8'd0;
      r_len  <= 8'd0;
      r_cnt  <= 8'd0;
      r_ovf  <= 1'b0;
    end else if (w_xfer) begin
      unique case (r_state)
        e_hdr: begin
          r_len  <= flit_i[7:0];
          r_type <= flit_i[15:8];
          r_mshr <= flit_i[23:16];
          r_data <= '0;
          r_cnt  <= 8'd0;
        end
        e_data: begin
          for (int k = 0; k < N; k++) begin
            if (r_cnt == 8'(k)) begin
              r_data[k*flit_width_p +: flit_width_p] <= flit_i;
            end
          end
          r_cnt <= w_cnt_inc;
        end
        e_drop: begin
          r_ovf <= 1'b1;
          r_cnt <= w_cnt_inc;
        end
        default: begin
        end
      endcase
    end
  end

  // Valid comes straight from the state register, never from flit_v_i.
  assign fill_v_o    = (r_state == e_out);
  assign fill_data_o = r_data;
  assign fill_type_o = r_type;
  assign fill_mshr_o = r_mshr;
  assign fill_len_o  = r_len;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_bp_piton_fill_assembler.sv
// Directed bench for bp_piton_fill_assembler at N=4 (64-bit flits, 256-bit fill).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_bp_piton_fill_assembler;

  logic         clk;
  logic         rst_n;
  logic [63:0]  flit;
  logic         flit_v;
  logic         flit_ready;
  logic [255:0] fill_data;
  logic [7:0]   fill_type;
  logic [7:0]   fill_mshr;
  logic [7:0]   fill_len;
  logic         fill_v;
  logic         fill_yumi;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  bp_piton_fill_assembler #(
    .flit_width_p(64),
    .fill_width_p(256)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flit_i      (flit),
    .flit_v_i    (flit_v),
    .flit_ready_o(flit_ready),
    .fill_data_o (fill_data),
    .fill_type_o (fill_type),
    .fill_mshr_o (fill_mshr),
    .fill_len_o  (fill_len),
    .fill_v_o    (fill_v),
    .fill_yumi_i (fill_yumi),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    flit   = d;
    flit_v = 1'b1;
    while (!flit_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%0d expected=<20", n);
    end
    @(posedge clk);
    #1;
    flit_v = 1'b0;
  endtask

  task automatic yumi();
    @(negedge clk);
    fill_yumi = 1'b1;
    @(posedge clk);
    #1;
    fill_yumi = 1'b0;
  endtask

  initial begin
    logic [255:0] snap;
    rst_n     = 1'b0;
    flit      = '0;
    flit_v    = 1'b0;
    fill_yumi = 1'b0;

    // reset state
    #2;
    chk("rst_fill_v", 256'(fill_v), 256'd0);
    chk("rst_data", fill_data, 256'd0);
    chk("rst_ovf", 256'(overflow), 256'd0);
    chk("rst_len", 256'(fill_len), 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 256'(flit_ready), 256'd1);

    // full line
    send(64'h050204);
    send(64'h11);
    send(64'h22);
    send(64'h33);
    @(negedge clk);
    chk("full_v_early", 256'(fill_v), 256'd0);
    send(64'h44);
    @(negedge clk);
    chk("full_v", 256'(fill_v), 256'd1);
    chk("full_data", fill_data,
        {64'h44, 64'h33, 64'h22, 64'h11});
    chk("full_len", 256'(fill_len), 256'd4);
    chk("full_type", 256'(fill_type), 256'h02);
    chk("full_mshr", 256'(fill_mshr), 256'h05);
    chk("full_ready", 256'(flit_ready), 256'd0);
    yumi();
    @(negedge clk);
    chk("full_post_v", 256'(fill_v), 256'd0);
    chk("full_post_rdy", 256'(flit_ready), 256'd1);

    // short message with bubbles
    send(64'h000102);
    send(64'hAA);
    repeat (3) @(negedge clk);
    chk("short_v_bubble", 256'(fill_v), 256'd0);
    send(64'hBB);
    @(negedge clk);
    chk("short_v", 256'(fill_v), 256'd1);
    chk("short_data", fill_data,
        {64'h0, 64'h0, 64'hBB, 64'hAA});
    chk("short_ovf", 256'(overflow), 256'd0);
    yumi();

    // zero length
    send(64'h030700);
    @(negedge clk);
    chk("zero_v", 256'(fill_v), 256'd1);
    chk("zero_data", fill_data, 256'd0);
    chk("zero_ready", 256'(flit_ready), 256'd0);
    @(negedge clk);
    @(negedge clk);
    chk("zero_ready_hold", 256'(flit_ready), 256'd0);
    yumi();

    // overflow L=6
    send(64'h0A0306);
    send(64'h101);
    send(64'h102);
    send(64'h103);
    send(64'h104);
    @(negedge clk);
    chk("ovf_v_at4", 256'(fill_v), 256'd0);
    chk("ovf_flag_at4", 256'(overflow), 256'd0);
    send(64'h105);
    @(negedge clk);
    chk("ovf_flag_at5", 256'(overflow), 256'd1);
    chk("ovf_v_at5", 256'(fill_v), 256'd0);
    send(64'h106);
    @(negedge clk);
    chk("ovf_v", 256'(fill_v), 256'd1);
    chk("ovf_data", fill_data,
        {64'h104, 64'h103, 64'h102, 64'h101});
    chk("ovf_len", 256'(fill_len), 256'd6);
    yumi();

    // backpressure
    send(64'h040502);
    send(64'hC1);
    send(64'hC2);
    @(negedge clk);
    chk("bp_v", 256'(fill_v), 256'd1);
    snap = fill_data;
    chk("bp_data", snap, {64'h0, 64'h0, 64'hC2, 64'hC1});
    flit   = 64'h060801;
    flit_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready", 256'(flit_ready), 256'd0);
      chk("bp_hold", fill_data, snap);
      chk("bp_hold_v", 256'(fill_v), 256'd1);
    end
    chk("bp_hold_len", 256'(fill_len), 256'd2);
    @(negedge clk);
    fill_yumi = 1'b1;
    @(posedge clk);
    #1;
    fill_yumi = 1'b0;
    @(negedge clk);
    chk("bp_hdr_ready", 256'(flit_ready), 256'd1);
    chk("bp_hdr_v", 256'(fill_v), 256'd0);
    @(posedge clk);
    #1;
    flit_v = 1'b0;
    @(negedge clk);
    chk("bp_new_len", 256'(fill_len), 256'd1);
    chk("bp_new_type", 256'(fill_type), 256'h08);
    send(64'hD1);
    @(negedge clk);
    chk("bp_new_v", 256'(fill_v), 256'd1);
    chk("bp_new_data", fill_data, {192'h0, 64'hD1});
    chk("bp_ovf_sticky", 256'(overflow), 256'd1);
    yumi();

    // L=255 must drain fully with no counter wrap
    send(64'h0000FF);
    for (int i = 1; i < 255; i++) send(64'(i));
    @(negedge clk);
    chk("l255_v_early", 256'(fill_v), 256'd0);
    send(64'd255);
    @(negedge clk);
    chk("l255_v", 256'(fill_v), 256'd1);
    chk("l255_data", fill_data,
        {64'd4, 64'd3, 64'd2, 64'd1});
    chk("l255_len", 256'(fill_len), 256'd255);
    yumi();

    // reset mid-message
    send(64'h000004);
    send(64'hE1);
    send(64'hE2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", fill_data, 256'd0);
    chk("mid_rst_v", 256'(fill_v), 256'd0);
    chk("mid_rst_ovf", 256'(overflow), 256'd0);
    chk("mid_rst_len", 256'(fill_len), 256'd0);
    chk("mid_rst_type", 256'(fill_type), 256'd0);
    chk("mid_rst_mshr", 256'(fill_mshr), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(64'h010901);
    send(64'hF1);
    @(negedge clk);
    chk("post_rst_v", 256'(fill_v), 256'd1);
    chk("post_rst_data", fill_data, {192'h0, 64'hF1});
    chk("post_rst_type", 256'(fill_type), 256'h09);
    chk("post_rst_mshr", 256'(fill_mshr), 256'h01);
    chk("post_rst_ovf", 256'(overflow), 256'd0);
    yumi();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
